// File: rtl/scoreboard_registers.sv
// Register file with a per-register scoreboard busy bit, NREAD read ports and NWRITE write ports.
// Latency: reads return one clock after the address is sampled; writes, allocs and flushes land at the edge.
// Backpressure: none; every port is accepted every cycle.
//
// Ports: clock/reset (sync, active-high); rd_addr -> rd_data/rd_busy (registered);
//        wr_en/wr_addr/wr_data write-back; alloc_en/alloc_addr marks a destination busy;
//        flush clears all busy bits.
// Optional feature: define SCOREBOARD_REGISTERS_BYPASS_EN to forward same-cycle write data
// and post-update busy state to the read ports.
module scoreboard_registers #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    input  logic                    flush
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NREAD*XLEN-1:0] rd_data_q;
    logic [NREAD*XLEN-1:0] rd_data_d;
    logic [NREAD-1:0]      rd_busy_q;
    logic [NREAD-1:0]      rd_busy_d;

    // Next register/busy state. Later write ports overwrite earlier ones, so the
    // highest-numbered port wins. Alloc is applied after writes so a new producer
    // keeps the register busy; flush overrides alloc but writes still land.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (alloc_en && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    // Read mux. Index 0 is hard-wired to zero / not busy.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int r = 0; r < NREAD; r++) begin
            if (rd_addr[r*AW +: AW] != '0) begin
`ifdef SCOREBOARD_REGISTERS_BYPASS_EN
                rd_data_d[r*XLEN +: XLEN] = regs_d[rd_addr[r*AW +: AW]];
                rd_busy_d[r]              = busy_d[rd_addr[r*AW +: AW]];
`else
                rd_data_d[r*XLEN +: XLEN] = regs_q[rd_addr[r*AW +: AW]];
                rd_busy_d[r]              = busy_q[rd_addr[r*AW +: AW]];
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_scoreboard_registers.sv
// Scoreboard bench for scoreboard_registers: directed stimulus pushes expected read
// results into a queue; a monitor pops and compares whenever a tagged read returns.
// Expectations follow the read-before-write behaviour unless bypass is compiled in.
module tb_scoreboard_registers;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;

    scoreboard_registers #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    logic chk_req = 1'b0;
    logic chk_vld = 1'b0;

    // A tagged read's result appears one edge after the address is sampled.
    always @(posedge clock) chk_vld <= chk_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clock);
            if (chk_vld) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL monitor: got an output with no expectation queued, expected one");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, ".d0"}, rd_data[31:0],       e.d0);
                    check({e.name, ".b0"}, {31'b0, rd_busy[0]}, {31'b0, e.b0});
                    check({e.name, ".d1"}, rd_data[63:32],      e.d1);
                    check({e.name, ".b1"}, {31'b0, rd_busy[1]}, {31'b0, e.b1});
                end
            end
        end
    end

    task automatic idle();
        reset    = 1'b0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        alloc_en = 1'b0;
        alloc_addr = '0;
        flush    = 1'b0;
        chk_req  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]               = 1'b1;
        wr_addr[p*AW +: AW]    = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] d0, input logic b0,
                             input logic [31:0] d1, input logic b1);
        exp_t e;
        e.name = name; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

`ifdef SCOREBOARD_REGISTERS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        idle();
        rd(5'd0, 5'd0);
        reset = 1'b1;
        tick();
        // Reset state: outputs zero during reset
        reset = 1'b1; rd(5'd5, 5'd5);
        expect_rd("reset_x5", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rd(5'd5, 5'd5);
        expect_rd("post_reset_x5", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        // Write x3, then read it
        wr(0, 5'd3, 32'hDEADBEEF); rd(5'd0, 5'd0);
        tick();
        rd(5'd3, 5'd3); wr(0, 5'd0, 32'h1234);
        expect_rd("rd_x3", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        rd(5'd0, 5'd0); alloc(5'd7);
        expect_rd("rd_x0", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rd(5'd7, 5'd3);
        expect_rd("alloc_x7", 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        wr(0, 5'd7, 32'h55);
        tick();
        // Read x7 while alloc + write x7=0x66 in the same cycle
        rd(5'd7, 5'd7); alloc(5'd7); wr(1, 5'd7, 32'h66);
        if (BYP) expect_rd("byp_x7", 32'h66, 1'b1, 32'h66, 1'b1);
        else     expect_rd("wb_x7",  32'h55, 1'b0, 32'h55, 1'b0);
        tick();
        rd(5'd7, 5'd7);
        expect_rd("alloc_wr_x7", 32'h66, 1'b1, 32'h66, 1'b1);
        tick();
        // Both ports write x9
        wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22);
        tick();
        wr(0, 5'd4, 32'h10); rd(5'd9, 5'd9);
        expect_rd("dual_wr_x9", 32'h22, 1'b0, 32'h22, 1'b0);
        tick();
        // Same-cycle write and read of x4
        wr(0, 5'd4, 32'hAA); rd(5'd4, 5'd4);
        if (BYP) expect_rd("rbw_x4", 32'hAA, 1'b0, 32'hAA, 1'b0);
        else     expect_rd("rbw_x4", 32'h10, 1'b0, 32'h10, 1'b0);
        tick();
        rd(5'd4, 5'd12); alloc(5'd12);
        expect_rd("x4_x12", 32'hAA, 1'b0, 32'h0, BYP);
        tick();
        rd(5'd12, 5'd12); alloc(5'd1);
        expect_rd("busy_x12", 32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        rd(5'd1, 5'd2); alloc(5'd2);
        expect_rd("x1_x2", 32'h0, 1'b1, 32'h0, BYP);
        tick();
        // Flush with alloc x8, and a write that must still land
        flush = 1'b1; alloc(5'd8); wr(0, 5'd10, 32'h77); rd(5'd1, 5'd2);
        expect_rd("flush_cycle", 32'h0, !BYP, 32'h0, !BYP);
        tick();
        rd(5'd8, 5'd10);
        expect_rd("after_flush_x8_x10", 32'h0, 1'b0, 32'h77, 1'b0);
        tick();
        rd(5'd1, 5'd2);
        expect_rd("after_flush_x1_x2", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        // Reset mid-operation beats write, alloc and pending reads
        reset = 1'b1; wr(0, 5'd5, 32'h99); alloc(5'd6); rd(5'd3, 5'd3);
        expect_rd("reset_mid", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rd(5'd5, 5'd6);
        expect_rd("reset_x5_x6", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rd(5'd3, 5'd7);
        expect_rd("reset_x3_x7", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rd(5'd9, 5'd4);
        expect_rd("reset_x9_x4", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        repeat (3) @(posedge clock);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scoreboard_registers.md
SCOREBOARD_REGISTERS -- requirements
Module: scoreboard_registers

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, read port count (>=1).
REQ-004 SHALL have parameter NWRITE, default 2, write port count (>=1).
REQ-005 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_addr  input  NREAD x AW  read port source register indices.
REQ-008 SHALL have port rd_data  output  NREAD x XLEN  registered read values.
REQ-009 SHALL have port rd_busy  output  NREAD  registered scoreboard busy flag per read port.
REQ-010 SHALL have port wr_en  input  NWRITE  write-back enables.
REQ-011 SHALL have port wr_addr  input  NWRITE x AW  write-back destination indices.
REQ-012 SHALL have port wr_data  input  NWRITE x XLEN  write-back values.
REQ-013 SHALL have port alloc_en  input  1  issue-stage request to mark a destination busy.
REQ-014 SHALL have port alloc_addr  input  AW  destination index to mark busy.
REQ-015 SHALL have port flush  input  1  clears all busy bits (pipeline squash).

Function
REQ-016 Register 0 SHALL read as zero with busy=0 always; writes and allocs to index 0 SHALL be ignored.
REQ-017 Reads SHALL have 1-cycle latency: rd_data/rd_busy at edge N+1 reflect rd_addr sampled at edge N.
REQ-018 A write with wr_en[i]=1 SHALL update register wr_addr[i] at the edge and clear its busy bit.
REQ-019 Multiple write ports targeting the same index in one cycle: the highest-numbered port SHALL win for data.
REQ-020 alloc_en=1 SHALL set busy[alloc_addr] at the edge.
REQ-021 Alloc and write-back to the same index in one cycle: busy SHALL end set (new producer wins) and the write data SHALL still be stored.
REQ-022 flush=1 SHALL clear all busy bits at the edge; it SHALL override a simultaneous alloc but SHALL NOT block writes.
REQ-023 Without bypass (see Configuration), a read of an index written in the same cycle SHALL return the pre-write value and pre-write busy (read-before-write).
REQ-024 Independent read ports addressing the same index SHALL return identical values.

Reset
REQ-025 reset=1 at an edge SHALL clear all registers to 0, all busy bits to 0, rd_data to 0 and rd_busy to 0.
REQ-026 reset SHALL take priority over flush, alloc and writes in the same cycle; no in-flight write SHALL survive it.
REQ-027 Reset asserted mid-operation SHALL produce zero outputs on the following edge regardless of pending reads.

Configuration
REQ-028 Macro SCOREBOARD_REGISTERS_BYPASS_EN, when defined, SHALL forward same-cycle write data to matching read ports (highest write port wins) and report busy as post-update state (alloc/flush applied).
REQ-029 When SCOREBOARD_REGISTERS_BYPASS_EN is undefined, REQ-023 read-before-write behaviour SHALL apply.

Verification
REQ-030 Reset then read x5 on both ports -> rd_data=0, rd_busy=0 one edge later.
REQ-031 Write x3=0xDEADBEEF, next cycle read x3 -> rd_data=0xDEADBEEF, rd_busy=0; write x0=0x1234, read x0 -> 0.
REQ-032 alloc x7; next cycle read x7 -> busy=1; write x7=0x55 -> following read busy=0, data=0x55; same-cycle alloc+write x7=0x66 -> busy=1, data=0x66.
REQ-033 Ports 0 and 1 both write x9 (0x11, 0x22) -> read x9 returns 0x22.
REQ-034 Same-cycle write x4=0xAA (x4 was 0x10) and read x4 -> 0xAA with BYPASS_EN, 0x10 without.
REQ-035 Allocate x1, x2; assert flush with alloc x8 and reset mid-sequence -> after flush all busy=0 including x8; after reset all data and busy 0.
